tomasulo_exe: RTL
=================

Name: tomasulo_exe

Overview:
- Fixed-latency integer execution pipeline that sits directly downstream of the reservation station.
- Consumes one issued instruction per cycle (operands already resolved), computes the result, and drives it onto the common data bus (CDB) exactly LATENCY_N cycles later.
- Exports an occupancy/schedule vector so the RS and CDB arbiter can avoid CDB slot collisions.
- Supports a pipeline flush that kills all in-flight operations.

Parameters:
- LATENCY_N, 2, issue-to-CDB latency in cycles; legal range 1..8.
- W, 32, datapath width.
- TAG_W, 4, CDB tag width.
- ROBID_W, 4, ROB index width.
- REG_W, 5, architectural register index width.
- IMM_W, 16, immediate width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- iss_vld  in  1  issue valid from RS.
- iss_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADDI, 6 SLT, 7 reserved.
- iss_rdata0  in  W  operand A.
- iss_rdata1  in  W  operand B.
- iss_imm  in  IMM_W  immediate (ADDI only).
- iss_tag  in  TAG_W  destination tag.
- iss_robid  in  ROBID_W  ROB index.
- iss_wa  in  REG_W  architectural destination.
- flush  in  1  kill all in-flight and same-cycle issue.
- cdb_vld  out  1  result valid on CDB.
- cdb_tag  out  TAG_W  result tag.
- cdb_wdata  out  W  result data.
- cdb_robid  out  ROBID_W  result ROB index.
- cdb_wa  out  REG_W  result destination register.
- sch  out  LATENCY_N+1  CDB schedule vector.
- inflight  out  4  count of valid pipeline stages.
- err  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset (rst_n low, async):
  - All stage valids, cdb_vld, sch, inflight and err go to 0 immediately.
  - Stage payloads are not reset.
  - Reset asserted mid-operation discards all in-flight ops; no CDB write occurs for them after release.
- Pipeline:
  - Stages s1..sLATENCY_N, each holding valid + {tag, robid, wa, result}.
  - ALU is evaluated combinationally on the iss_* inputs and captured into s1.
  - Each stage advances one per cycle unconditionally; there is no backpressure and no stall input.
  - sLATENCY_N registers drive cdb_* directly.
  - Issue at edge-cycle t -> cdb_vld=1 in cycle t+LATENCY_N, for exactly one cycle.
- Payload enables:
  - Stage payload regs load only when the upstream valid is 1.
  - cdb_tag, cdb_wdata, cdb_robid and cdb_wa hold their last value while cdb_vld=0.
- Arithmetic (all W-bit):
  - ADD: a+b, wrap-around, no overflow flag.
  - SUB: a-b, two's complement wrap.
  - AND, OR, XOR: bitwise.
  - ADDI: a + sign-extended imm.
  - SLT: 1 if signed a < signed b, else 0.
  - Opcode 7: result 0, op still completes to CDB, and err set to 1 (sticky until reset). err sets only if iss_vld=1.
- Schedule vector:
  - sch[k] = valid of stage s(LATENCY_N-k) for k = 0..LATENCY_N-1; sch[0] equals cdb_vld.
  - sch[LATENCY_N] = iss_vld & ~flush (combinational).
  - Bit k=1 means the CDB is claimed by this unit k cycles from now.
- inflight:
  - Popcount of s1..sLATENCY_N valids, registered view; it does not include the current iss_vld.
  - Max value LATENCY_N.
- Flush:
  - flush=1 in cycle t clears all stage valids at the next edge; cdb_vld=0 in cycle t+1.
  - An issue in cycle t is dropped.
  - An op already on the CDB in cycle t (cdb_vld=1) is still presented in cycle t; flush does not gate outputs combinationally.
- Issue on consecutive cycles: back-to-back results appear on consecutive cycles in issue order.
- LATENCY_N=1: s1 drives CDB; sch is 2 bits wide.

Test Plan:
- Reset then idle 10 cycles -> cdb_vld=0, sch=0, inflight=0, err=0 throughout.
- LATENCY_N=2; issue ADD a=0xFFFFFFFF b=2 tag=3 robid=5 wa=7 at cycle 0 -> cycle 2: cdb_vld=1, wdata=0x00000001, tag=3, robid=5, wa=7; cycle 3: cdb_vld=0.
- Back-to-back over 4 cycles:
  - Stimulus: SUB 5-7, ADDI a=10 imm=0xFFFF, SLT a=0x80000000 b=1, XOR 0xF0F0 ^ 0x0FF0.
  - Response: results 0xFFFFFFFE, 9, 1, 0xFF00 on consecutive cycles 2..5.
  - sch and inflight track correctly (inflight=2 in steady state).
- Issue at cycles 0 and 1, flush at cycle 1:
  - Cycle-1 issue is dropped, and the cycle-0 op is killed (cdb_vld=0 at cycle 2).
  - Repeat with flush at cycle 2: the cycle-0 result is still visible at cycle 2, and the cycle-1 op is killed.
- Issue opcode 7 -> CDB write with wdata=0 at +LATENCY_N, and err=1 persists until rst_n pulse.
- Issue at cycles 0..1, assert rst_n low asynchronously mid-cycle 1 -> outputs clear immediately; after release no cdb_vld ever asserts for those ops.

Source files
------------

// File: rtl/tomasulo_exe.sv
// Fixed-latency integer execution pipe: issued op is computed on entry and driven onto the CDB LATENCY_N cycles later.
// No backpressure; flush or reset kills every in-flight op, and the exported schedule vector lets the RS avoid CDB slot collisions.
module tomasulo_exe #(
  parameter int LATENCY_N = 2,
  parameter int W         = 32,
  parameter int TAG_W     = 4,
  parameter int ROBID_W   = 4,
  parameter int REG_W     = 5,
  parameter int IMM_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_vld,
  input  logic [2:0]           iss_op,
  input  logic [W-1:0]         iss_rdata0,
  input  logic [W-1:0]         iss_rdata1,
  input  logic [IMM_W-1:0]     iss_imm,
  input  logic [TAG_W-1:0]     iss_tag,
  input  logic [ROBID_W-1:0]   iss_robid,
  input  logic [REG_W-1:0]     iss_wa,
  input  logic                 flush,
  output logic                 cdb_vld,
  output logic [TAG_W-1:0]     cdb_tag,
  output logic [W-1:0]         cdb_wdata,
  output logic [ROBID_W-1:0]   cdb_robid,
  output logic [REG_W-1:0]     cdb_wa,
  output logic [LATENCY_N:0]   sch,
  output logic [3:0]           inflight,
  output logic                 err
);

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [ROBID_W-1:0] robid;
    logic [REG_W-1:0]   wa;
    logic [W-1:0]       res;
  } pay_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_ADDI = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;

  logic [W-1:0]           alu_res;
  logic                   illegal_op;
  logic [LATENCY_N-1:0]   vld_d, vld_q;
  pay_t                   pay_d [LATENCY_N];
  pay_t                   pay_q [LATENCY_N];
  logic [3:0]             inflight_d, inflight_q;
  logic                   err_d, err_q;

  always_comb begin
    alu_res    = '0;
    illegal_op = 1'b0;
    case (iss_op)
      OP_ADD:  alu_res = iss_rdata0 + iss_rdata1;
      OP_SUB:  alu_res = iss_rdata0 - iss_rdata1;
      OP_AND:  alu_res = iss_rdata0 & iss_rdata1;
      OP_OR:   alu_res = iss_rdata0 | iss_rdata1;
      OP_XOR:  alu_res = iss_rdata0 ^ iss_rdata1;
      OP_ADDI: alu_res = iss_rdata0 + {{(W-IMM_W){iss_imm[IMM_W-1]}}, iss_imm};
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(iss_rdata0) < $signed(iss_rdata1))};
      default: illegal_op = 1'b1;
    endcase
  end

  // Payloads load only behind a surviving valid, so a killed op never disturbs the held CDB fields.
  always_comb begin
    vld_d    = '0;
    pay_d    = pay_q;
    vld_d[0] = iss_vld & ~flush;
    if (vld_d[0]) begin
      pay_d[0] = '{tag: iss_tag, robid: iss_robid, wa: iss_wa, res: alu_res};
    end
    for (int i = 1; i < LATENCY_N; i++) begin
      vld_d[i] = vld_q[i-1] & ~flush;
      if (vld_d[i]) pay_d[i] = pay_q[i-1];
    end
  end

  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < LATENCY_N; i++) begin
      inflight_d = inflight_d + 4'(vld_d[i]);
    end
    err_d = err_q | (iss_vld & illegal_op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    pay_q <= pay_d;
  end

  assign cdb_vld   = vld_q[LATENCY_N-1];
  assign cdb_tag   = pay_q[LATENCY_N-1].tag;
  assign cdb_wdata = pay_q[LATENCY_N-1].res;
  assign cdb_robid = pay_q[LATENCY_N-1].robid;
  assign cdb_wa    = pay_q[LATENCY_N-1].wa;
  assign inflight  = inflight_q;
  assign err       = err_q;

  // The issue-slot bit is gated by rst_n so the whole vector reads zero while reset is held.
  always_comb begin
    sch = '0;
    for (int k = 0; k < LATENCY_N; k++) begin
      sch[k] = vld_q[LATENCY_N-1-k];
    end
    sch[LATENCY_N] = iss_vld & ~flush & rst_n;
  end

endmodule
